// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard inputs and stall/flush controls between the pipeline and pipe_hazard_ctrl
interface pipe_hazard_ctrl_if;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_jflag;
    logic        ex_valid;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        ex_br_taken;
    logic        mem_req;
    logic        mem_ack;
    logic        freeze_if;
    logic        freeze_id;
    logic        freeze_ex;
    logic        bubble_ex;
    logic        flush_if;
    logic        flush_id;
    logic        mem_timeout;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_jflag,
        output ex_valid, ex_is_load, ex_rd, ex_br_taken, mem_req, mem_ack,
        input  freeze_if, freeze_id, freeze_ex, bubble_ex, flush_if, flush_id,
        input  mem_timeout, ctrl_state, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_jflag,
        input  ex_valid, ex_is_load, ex_rd, ex_br_taken, mem_req, mem_ack,
        output freeze_if, freeze_id, freeze_ex, bubble_ex, flush_if, flush_id,
        output mem_timeout, ctrl_state, stall_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller; PIPE_CTRL_PERF_EN adds a stall-cycle counter
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic clk,
    input  logic rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [7:0] FLUSH_INIT = 8'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TMO_LIMIT  = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       timeout_q, timeout_d;
    logic       load_use;
    logic       frz_if, frz_id, frz_ex, bub_ex, fl_if, fl_id;

    assign load_use = hz.ex_valid && hz.ex_is_load && (hz.ex_rd != 5'd0) && hz.id_valid &&
                      ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            fcnt_q    <= 8'd0;
            tcnt_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        tcnt_d    = tcnt_q;
        timeout_d = timeout_q;
        frz_if    = 1'b0;
        frz_id    = 1'b0;
        frz_ex    = 1'b0;
        bub_ex    = 1'b0;
        fl_if     = 1'b0;
        fl_id     = 1'b0;
        case (state_q)
            RUN: begin
                if (hz.ex_br_taken) begin
                    fl_if  = 1'b1;
                    fl_id  = 1'b1;
                    bub_ex = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = FLUSH_INIT;
                    end
                end else if (hz.mem_req && !hz.mem_ack) begin
                    frz_if  = 1'b1;
                    frz_id  = 1'b1;
                    frz_ex  = 1'b1;
                    state_d = MEM_WAIT;
                    tcnt_d  = 8'd1;
                end else if (load_use) begin
                    frz_if = 1'b1;
                    frz_id = 1'b1;
                    bub_ex = 1'b1;
                end else if (hz.id_valid && hz.id_jflag) begin
                    fl_if = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Upstream is frozen, so branch/load-use/jump inputs are stale here.
                if (hz.mem_ack) begin
                    state_d = RUN;
                end else if (tcnt_q == TMO_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = RUN;
                end else begin
                    frz_if = 1'b1;
                    frz_id = 1'b1;
                    frz_ex = 1'b1;
                    if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
                end
            end
            FLUSH: begin
                fl_if = 1'b1;
                fl_id = 1'b1;
                if (fcnt_q != 8'd0) fcnt_d = fcnt_q - 8'd1;
                if (fcnt_q <= 8'd1) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs follow inputs combinationally, so reset must mask them explicitly.
    assign hz.freeze_if   = rst & frz_if;
    assign hz.freeze_id   = rst & frz_id;
    assign hz.freeze_ex   = rst & frz_ex;
    assign hz.bubble_ex   = rst & bub_ex;
    assign hz.flush_if    = rst & fl_if;
    assign hz.flush_id    = rst & fl_id;
    assign hz.mem_timeout = timeout_q;
    assign hz.ctrl_state  = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 32'd0;
        end else if ((hz.freeze_id || hz.flush_id) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign hz.stall_count = stall_q;
`else
    assign hz.stall_count = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam int FC = 2;
    localparam int MT = 15;

    typedef struct {
        logic       rst;
        logic       id_valid;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic       id_jflag;
        logic       ex_valid;
        logic       ex_is_load;
        logic [4:0] ex_rd;
        logic       ex_br_taken;
        logic       mem_req;
        logic       mem_ack;
    } stim_t;

    typedef struct {
        int          cyc;
        logic [6:0]  ctl;
        logic [1:0]  st;
        logic [31:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    pipe_hazard_ctrl_if hz_if ();

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: an access either is pending (with stall count so far) or not,
    // and a taken branch leaves a number of further flush cycles to spend.
    int     flush_left = 0;
    int     stalled    = 0;
    bit     waiting    = 0;
    bit     tflag      = 0;
    longint ctr        = 0;

    task automatic model_step(input stim_t s, output exp_t e);
        logic fi, fd, fe, bx, li, ld, lu;
        e.cyc = cyc;
        if (!s.rst) begin
            e.ctl = '0; e.st = 2'd0; e.sc = 32'd0;
            flush_left = 0; waiting = 0; stalled = 0; tflag = 0; ctr = 0;
            return;
        end
        fi = 0; fd = 0; fe = 0; bx = 0; li = 0; ld = 0;
`ifdef PIPE_CTRL_PERF_EN
        e.sc = 32'(ctr);
`else
        e.sc = 32'd0;
`endif
        e.ctl[0] = tflag;
        lu = s.ex_valid && s.ex_is_load && s.ex_rd != 0 && s.id_valid &&
             (s.ex_rd == s.id_rs || (s.id_uses_rt && s.ex_rd == s.id_rt));
        if (waiting) begin
            e.st = 2'd1;
            if (s.mem_ack) waiting = 0;
            else if (stalled >= MT) begin waiting = 0; tflag = 1; end
            else begin fi = 1; fd = 1; fe = 1; stalled++; end
        end else if (flush_left > 0) begin
            e.st = 2'd2;
            li = 1; ld = 1;
            flush_left--;
        end else begin
            e.st = 2'd0;
            if (s.ex_br_taken) begin
                li = 1; ld = 1; bx = 1;
                flush_left = FC - 1;
            end else if (s.mem_req && !s.mem_ack) begin
                fi = 1; fd = 1; fe = 1;
                waiting = 1; stalled = 1;
            end else if (lu) begin
                fi = 1; fd = 1; bx = 1;
            end else if (s.id_valid && s.id_jflag) begin
                li = 1;
            end
        end
        e.ctl[6:1] = {fi, fd, fe, bx, li, ld};
        if ((fd || ld) && ctr < 64'hFFFF_FFFF) ctr++;
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        @(negedge clk);
        #1;
        rst                 = s.rst;
        hz_if.id_valid      = s.id_valid;
        hz_if.id_rs         = s.id_rs;
        hz_if.id_rt         = s.id_rt;
        hz_if.id_uses_rt    = s.id_uses_rt;
        hz_if.id_jflag      = s.id_jflag;
        hz_if.ex_valid      = s.ex_valid;
        hz_if.ex_is_load    = s.ex_is_load;
        hz_if.ex_rd         = s.ex_rd;
        hz_if.ex_br_taken   = s.ex_br_taken;
        hz_if.mem_req       = s.mem_req;
        hz_if.mem_ack       = s.mem_ack;
        model_step(s, e);
        sb.push_back(e);
        cyc++;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1; s.id_valid = 0; s.id_rs = 0; s.id_rt = 0; s.id_uses_rt = 0;
        s.id_jflag = 0; s.ex_valid = 0; s.ex_is_load = 0; s.ex_rd = 0;
        s.ex_br_taken = 0; s.mem_req = 0; s.mem_ack = 0;
        return s;
    endfunction

    function automatic stim_t rnd(input bit slow_ack, input bit allow_rst);
        stim_t s;
        s.rst         = allow_rst ? ($urandom_range(0, 199) != 0) : 1'b1;
        s.id_valid    = ($urandom_range(0, 3) != 0);
        s.id_rs       = 5'($urandom_range(0, 3));
        s.id_rt       = 5'($urandom_range(0, 3));
        s.id_uses_rt  = 1'($urandom_range(0, 1));
        s.id_jflag    = ($urandom_range(0, 5) == 0);
        s.ex_valid    = ($urandom_range(0, 3) != 0);
        s.ex_is_load  = ($urandom_range(0, 2) == 0);
        s.ex_rd       = 5'($urandom_range(0, 3));
        s.ex_br_taken = ($urandom_range(0, 9) == 0);
        s.mem_req     = ($urandom_range(0, 5) == 0);
        s.mem_ack     = slow_ack ? ($urandom_range(0, 40) == 0) : ($urandom_range(0, 2) == 0);
        return s;
    endfunction

    initial begin : monitor
        exp_t e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {hz_if.freeze_if, hz_if.freeze_id, hz_if.freeze_ex, hz_if.bubble_ex,
                       hz_if.flush_if, hz_if.flush_id, hz_if.mem_timeout};
                total++;
                if (got !== e.ctl) begin
                    bad++;
                    $display("FAIL controls cyc=%0d got=%b want=%b (frz_if,frz_id,frz_ex,bub,fl_if,fl_id,tmo)",
                             e.cyc, got, e.ctl);
                end
                total++;
                if (hz_if.ctrl_state !== e.st) begin
                    bad++;
                    $display("FAIL ctrl_state cyc=%0d got=%0d want=%0d", e.cyc, hz_if.ctrl_state, e.st);
                end
                total++;
                if (hz_if.stall_count !== e.sc) begin
                    bad++;
                    $display("FAIL stall_count cyc=%0d got=%0d want=%0d", e.cyc, hz_if.stall_count, e.sc);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        stim_t s;
        rst = 1'b0;
        // Reset held with busy inputs: everything must read zero.
        for (int i = 0; i < 3; i++) begin
            s = rnd(0, 0);
            s.rst = 0; s.ex_br_taken = 1; s.mem_req = 1;
            apply(s);
        end
        apply(idle());
        // Load-use on rs, then idle.
        s = idle(); s.ex_valid = 1; s.ex_is_load = 1; s.ex_rd = 5; s.id_valid = 1; s.id_rs = 5;
        apply(s); apply(idle());
        s.ex_rd = 0; s.id_rs = 0;
        apply(s); apply(idle());
        s = idle(); s.ex_valid = 1; s.ex_is_load = 1; s.ex_rd = 5; s.id_valid = 1; s.id_rs = 1; s.id_rt = 5;
        apply(s);
        s.id_uses_rt = 1;
        apply(s); apply(idle());
        // Taken branch with a simultaneous load-use: branch wins.
        s = idle(); s.ex_br_taken = 1; s.ex_valid = 1; s.ex_is_load = 1; s.ex_rd = 5; s.id_valid = 1; s.id_rs = 5;
        apply(s);
        s = idle(); s.mem_req = 1;
        apply(s); apply(idle()); apply(idle());
        // Memory wait acked on the 4th cycle.
        s = idle(); s.mem_req = 1;
        for (int i = 0; i < 3; i++) apply(s);
        s.mem_ack = 1;
        apply(s); apply(idle());
        // No ack: timeout then sticky flag.
        s = idle(); s.mem_req = 1;
        for (int i = 0; i < 20; i++) apply(s);
        apply(idle()); apply(idle());
        // Second wait aborted by reset.
        for (int i = 0; i < 5; i++) apply(s);
        s.rst = 0;
        apply(s);
        s.rst = 1; s.mem_req = 0;
        apply(s); apply(idle());
        // Jump in decode.
        s = idle(); s.id_valid = 1; s.id_jflag = 1;
        apply(s); apply(idle());
        // Randomized traffic, second half with rare acks to exercise timeouts.
        for (int i = 0; i < 3000; i++) apply(rnd(i >= 1500, 1));
        apply(idle());
        repeat (3) @(negedge clk);
        #5;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline, placed beside the decode stage. It drives the decode-stage freeze input and the fetch/decode flush and EX bubble controls. It detects load-use hazards against the instruction in decode, sequences multi-cycle data-memory waits with a timeout, and flushes wrong-path instructions after jumps and taken branches. All outputs are a single-cycle decode of controller state plus current-cycle hazard inputs.

## Interface
- FLUSH_CYCLES, 2, cycles of fetch/decode flush after a taken branch (1..15)
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before abort (1..255)
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a valid instruction (decode done flag)
- id_rs  in  5  decode register-file read address port 0
- id_rt  in  5  decode register-file read address port 1
- id_uses_rt  in  1  decode instruction reads rt (R-type, sw, beq/bne)
- id_jflag  in  1  decode instruction is j/jr
- ex_valid  in  1  EX holds a valid instruction
- ex_is_load  in  1  EX instruction is lw
- ex_rd  in  5  EX destination register
- ex_br_taken  in  1  EX branch resolved taken
- mem_req  in  1  MEM stage issuing a data-memory access
- mem_ack  in  1  data memory completes access this cycle
- freeze_if  out  1  hold PC and fetch register
- freeze_id  out  1  hold decode output registers
- freeze_ex  out  1  hold EX/MEM registers
- bubble_ex  out  1  insert no-op into EX next cycle
- flush_if  out  1  squash fetched instruction
- flush_id  out  1  squash decode instruction
- mem_timeout  out  1  sticky: a memory access was aborted
- ctrl_state  out  2  current state (RUN=0, MEM_WAIT=1, FLUSH=2)
- stall_count  out  32  stall-cycle counter (only when PIPE_CTRL_PERF_EN)

## Operation
- States: RUN, MEM_WAIT, FLUSH.
- Load-use hazard is a combinational term: ex_valid & ex_is_load & ex_rd!=0 & id_valid & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
- RUN evaluates the following in strict priority:
  1. ex_br_taken: flush_if=1, flush_id=1, bubble_ex=1. If FLUSH_CYCLES>1, go to FLUSH with fcnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  2. mem_req & !mem_ack: freeze_if=freeze_id=freeze_ex=1. Go to MEM_WAIT with tcnt=1.
  3. Load-use hazard: freeze_if=1, freeze_id=1, bubble_ex=1 for this cycle only. Stay in RUN.
  4. id_valid & id_jflag: flush_if=1. Stay in RUN.
  5. Otherwise, all controls are 0.
- mem_req & mem_ack in the same cycle in RUN completes with no stall.
- MEM_WAIT:
  - freeze_if, freeze_id and freeze_ex are held at 1.
  - ex_br_taken, load-use and jflag are ignored because the upstream stages are frozen.
  - mem_ack returns to RUN; the freezes drop in the ack cycle.
  - When tcnt==MEM_TIMEOUT without ack: set mem_timeout, return to RUN, and drop the freezes that cycle.
  - Otherwise tcnt increments.
- FLUSH:
  - flush_if=1 and flush_id=1; freezes are 0.
  - fcnt decrements; at fcnt==1 return to RUN.
  - mem_req in FLUSH is ignored (flushed slots issue no memory access).
- Counters are 8-bit and saturating, with no wrap-around.
- mem_timeout clears only on reset.

## Timing
- While rst is low:
  - All outputs are 0.
  - ctrl_state=RUN.
  - Counters are 0.
- The first evaluation happens at the first rising clk after rst deasserts.
- Output latency is 0 cycles: controls are valid in the same cycle as the causing inputs.
- State transitions take effect at the next clk edge.
- A load-use stall lasts exactly 1 cycle.
- A branch flush lasts exactly FLUSH_CYCLES cycles.
- A memory stall lasts until the ack cycle or MEM_TIMEOUT cycles, whichever comes first.
- Asserting reset mid-MEM_WAIT or mid-FLUSH aborts immediately to RUN with all outputs 0.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_count increments on every cycle where freeze_id | flush_id is 1.
  - It saturates at 32'hFFFF_FFFF and is cleared by reset.
- PIPE_CTRL_PERF_EN undefined: stall_count is tied to 0 and no counter logic is built.

## Test plan
- Reset: hold rst=0 with arbitrary inputs -> all outputs 0 and ctrl_state=0; release -> RUN.
- Load-use: EX lw with ex_rd=5, decode id_rs=5 -> one cycle of freeze_if=freeze_id=bubble_ex=1, then 0.
  - Same with ex_rd=0 -> no stall.
  - id_rt=5 with id_uses_rt=0 -> no stall.
- Taken branch, FLUSH_CYCLES=2: ex_br_taken pulse -> flush_if=flush_id=1 for 2 cycles, bubble_ex=1 in cycle 1, then RUN.
  - Simultaneous load-use in that cycle -> branch wins, no freeze.
- Memory wait: mem_req held, mem_ack on the 4th cycle -> freezes high for cycles 1-3 and low in the ack cycle.
  - With PIPE_CTRL_PERF_EN -> stall_count=3.
- Timeout, MEM_TIMEOUT=15: mem_req with no ack -> after 15 cycles mem_timeout=1 (sticky), state RUN.
  - Assert rst mid-wait on a second run -> mem_timeout=0 and state RUN.
- Jump: id_valid=1, id_jflag=1 -> flush_if=1 for 1 cycle, freeze_id=0, state unchanged.
